// File: rtl/prog_loader.sv
// Boot-time program loader: streams a data image into data BRAM, then a program into
// instruction BRAM, then releases the core. Define PROG_LOADER_CHECKSUM_EN for a trailer checksum.
module prog_loader #(
  parameter int ADDR_W  = 12,
  parameter int I_DEPTH = 1024,
  parameter int D_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  output logic [ADDR_W-1:0] i_w_addr,
  output logic [31:0]       i_w_dat,
  output logic              i_w_enb,
  output logic [3:0]        i_w_byte_enb,
  output logic [ADDR_W-1:0] d_w_addr,
  output logic [31:0]       d_w_dat,
  output logic              d_w_enb,
  output logic [3:0]        d_w_byte_enb,
  output logic              d_bram_init_done,
  output logic              pc_stall,
  output logic              done,
  output logic              error
);
  localparam int          CW    = ADDR_W - 2;
  localparam logic [16:0] I_LIM = 17'(I_DEPTH);
  localparam logic [16:0] D_LIM = 17'(D_DEPTH);

  // REL holds for one cycle after the final write so it lands before the core is released.
  typedef enum logic [3:0] {
    IDLE, HDR_I, HDR_D, LOAD_D, LOAD_I, CHK, REL, RUN, ERR
  } state_t;

  state_t        state, nxt, fin_st;
  logic [15:0]   n_i, n_d, hdr;
  logic [CW-1:0] cnt;
  logic [16:0]   cnt_nx;
  logic          acc, restart, hdr_bad, last_d, last_i;

  assign acc     = s_valid & s_ready;
  assign hdr     = s_data[15:0];
  assign restart = start & (state == IDLE || state == RUN || state == ERR);
  assign hdr_bad = ({1'b0, n_i} > I_LIM) || ({1'b0, hdr} > D_LIM);
  assign cnt_nx  = 17'(cnt) + 17'd1;
  assign last_d  = (cnt_nx == {1'b0, n_d});
  assign last_i  = (cnt_nx == {1'b0, n_i});

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [31:0] sum;
  logic        sum_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sum <= '0;
    else if (restart)
      sum <= '0;
    else if (acc && (state == LOAD_D || state == LOAD_I))
      sum <= sum + s_data;
  end

  assign sum_ok = (s_data == sum);
  assign fin_st = CHK;
`else
  assign fin_st = REL;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, RUN, ERR: if (start) nxt = HDR_I;
      HDR_I:          if (acc) nxt = HDR_D;
      HDR_D: begin
        if (acc) begin
          if (hdr_bad)       nxt = ERR;
          else if (hdr != 0) nxt = LOAD_D;
          else if (n_i != 0) nxt = LOAD_I;
          else               nxt = fin_st;
        end
      end
      LOAD_D: if (acc && last_d) nxt = (n_i != 0) ? LOAD_I : fin_st;
      LOAD_I: if (acc && last_i) nxt = fin_st;
      CHK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (acc) nxt = sum_ok ? REL : ERR;
`else
        nxt = ERR;
`endif
      end
      REL:     nxt = RUN;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready          = 1'b0;
    done             = 1'b0;
    d_bram_init_done = 1'b0;
    pc_stall         = 1'b1;
    error            = 1'b0;
    case (state)
      HDR_I, HDR_D, LOAD_D, LOAD_I, CHK: s_ready = 1'b1;
      RUN: begin
        pc_stall         = 1'b0;
        done             = 1'b1;
        d_bram_init_done = 1'b1;
      end
      ERR:     error = 1'b1;
      default: ;
    endcase
  end

  // One shared word index; it restarts at zero when the data phase hands over to the program phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_i <= '0;
      n_d <= '0;
      cnt <= '0;
    end else if (restart) begin
      n_i <= '0;
      n_d <= '0;
      cnt <= '0;
    end else if (acc) begin
      case (state)
        HDR_I:  n_i <= hdr;
        HDR_D: begin
          n_d <= hdr;
          cnt <= '0;
        end
        LOAD_D:  cnt <= last_d ? '0 : cnt + 1'b1;
        LOAD_I:  cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_w_addr     <= '0;
      i_w_dat      <= '0;
      i_w_enb      <= 1'b0;
      i_w_byte_enb <= '0;
      d_w_addr     <= '0;
      d_w_dat      <= '0;
      d_w_enb      <= 1'b0;
      d_w_byte_enb <= '0;
    end else begin
      i_w_enb      <= 1'b0;
      i_w_byte_enb <= '0;
      d_w_enb      <= 1'b0;
      d_w_byte_enb <= '0;
      if (acc && state == LOAD_D) begin
        d_w_enb      <= 1'b1;
        d_w_byte_enb <= 4'b1111;
        d_w_addr     <= {cnt, 2'b00};
        d_w_dat      <= s_data;
      end
      if (acc && state == LOAD_I) begin
        i_w_enb      <= 1'b1;
        i_w_byte_enb <= 4'b1111;
        i_w_addr     <= {cnt, 2'b00};
        i_w_dat      <= s_data;
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: a stream-level model predicts every BRAM write,
// its cycle, and the final run/error status.
module tb_prog_loader;
  localparam int ADDR_W  = 12;
  localparam int I_DEPTH = 1024;
  localparam int D_DEPTH = 1024;

  typedef logic [31:0] wq_t[$];
  typedef struct {
    int          cyc;
    logic        en;
    logic [3:0]  be;
    logic [11:0] addr;
    logic [31:0] dat;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic [31:0]       s_data = '0;
  logic              s_ready;
  logic [ADDR_W-1:0] i_w_addr, d_w_addr;
  logic [31:0]       i_w_dat, d_w_dat;
  logic              i_w_enb, d_w_enb;
  logic [3:0]        i_w_byte_enb, d_w_byte_enb;
  logic              d_bram_init_done, pc_stall, done, error;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_q[$];
  wr_t  dq[$], iq[$];
  int   done_cyc = -1;
  int   stall_cyc = -1;
  logic done_q = 1'b0;
  logic stall_q = 1'b1;

  prog_loader #(.ADDR_W(ADDR_W), .I_DEPTH(I_DEPTH), .D_DEPTH(D_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .i_w_addr(i_w_addr), .i_w_dat(i_w_dat), .i_w_enb(i_w_enb), .i_w_byte_enb(i_w_byte_enb),
    .d_w_addr(d_w_addr), .d_w_dat(d_w_dat), .d_w_enb(d_w_enb), .d_w_byte_enb(d_w_byte_enb),
    .d_bram_init_done(d_bram_init_done), .pc_stall(pc_stall), .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Writes are logged with the index of the edge that launched them.
  always @(negedge clk) begin
    if (d_w_enb || d_w_byte_enb != 4'h0) dq.push_back('{cyc, d_w_enb, d_w_byte_enb, d_w_addr, d_w_dat});
    if (i_w_enb || i_w_byte_enb != 4'h0) iq.push_back('{cyc, i_w_enb, i_w_byte_enb, i_w_addr, i_w_dat});
    if (done && !done_q) done_cyc = cyc;
    if (!pc_stall && stall_q) stall_cyc = cyc;
    done_q  = done;
    stall_q = pc_stall;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic wq_t rnd(input int n);
    wq_t q;
    for (int k = 0; k < n; k++) q.push_back($urandom);
    return q;
  endfunction

  function automatic wq_t mk(input int ni, input int nd, input wq_t pay, input logic [15:0] junk);
    wq_t w;
    w.push_back({junk, 16'(ni)});
    w.push_back({junk ^ 16'h5a5a, 16'(nd)});
    foreach (pay[k]) w.push_back(pay[k]);
`ifdef PROG_LOADER_CHECKSUM_EN
    begin
      logic [31:0] s = '0;
      foreach (pay[k]) s += pay[k];
      w.push_back(s);
    end
`endif
    return w;
  endfunction

  // mode 0: always valid, 1: valid every other cycle, 2: random valid
  task automatic drive(input wq_t w, input int mode);
    int idx = 0;
    int t = 0;
    bit tog = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (idx < w.size() && t < 4 * w.size() + 40) begin
      tog = !tog;
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = tog;
        default: s_valid = 1'($urandom_range(1, 0));
      endcase
      s_data = s_valid ? w[idx] : $urandom;
      if (s_valid && s_ready) begin
        acc_q.push_back(cyc + 1);
        idx++;
      end
      @(negedge clk);
      t++;
    end
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic test_stream(input string name, input wq_t w, input int mode);
    int ni, nd, n_acc, t, last;
    logic bad, exp_err;
    acc_q.delete(); dq.delete(); iq.delete();
    done_cyc = -1; stall_cyc = -1;
    drive(w, mode);
    t = 0;
    while (!(done || error) && t < 60) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (!(done || error)) begin
      n_fail++;
      $display("FAIL %s timeout: done=%0b error=%0b, required one of them high", name, done, error);
    end
    repeat (2) @(negedge clk);

    ni      = int'(w[0][15:0]);
    nd      = int'(w[1][15:0]);
    bad     = (ni > I_DEPTH) || (nd > D_DEPTH);
    n_acc   = bad ? 2 : 2 + ni + nd;
    exp_err = bad;
`ifdef PROG_LOADER_CHECKSUM_EN
    if (!bad) begin
      logic [31:0] s = '0;
      for (int k = 0; k < ni + nd; k++) s += w[2 + k];
      n_acc++;
      exp_err = (w[w.size() - 1] != s);
    end
`endif

    n_cmp++;
    if (acc_q.size() !== n_acc) begin
      n_fail++;
      $display("FAIL %s accepts: got %0d, required %0d", name, acc_q.size(), n_acc);
    end
    n_cmp++;
    if (dq.size() !== (bad ? 0 : nd) || iq.size() !== (bad ? 0 : ni)) begin
      n_fail++;
      $display("FAIL %s write counts: d=%0d i=%0d, required d=%0d i=%0d",
               name, dq.size(), iq.size(), bad ? 0 : nd, bad ? 0 : ni);
    end
    for (int k = 0; k < dq.size() && k < nd && !bad; k++) begin
      n_cmp++;
      if ({dq[k].en, dq[k].be, dq[k].addr, dq[k].dat} !== {1'b1, 4'hF, 12'(k * 4), w[2 + k]}) begin
        n_fail++;
        $display("FAIL %s dwrite[%0d]: en=%0b be=%h addr=%h dat=%h, required 1 f %h %h",
                 name, k, dq[k].en, dq[k].be, dq[k].addr, dq[k].dat, 12'(k * 4), w[2 + k]);
      end
      if (2 + k < acc_q.size()) begin
        n_cmp++;
        if (dq[k].cyc !== acc_q[2 + k]) begin
          n_fail++;
          $display("FAIL %s dwrite[%0d] cycle: %0d, required %0d", name, k, dq[k].cyc, acc_q[2 + k]);
        end
      end
    end
    for (int k = 0; k < iq.size() && k < ni && !bad; k++) begin
      n_cmp++;
      if ({iq[k].en, iq[k].be, iq[k].addr, iq[k].dat} !== {1'b1, 4'hF, 12'(k * 4), w[2 + nd + k]}) begin
        n_fail++;
        $display("FAIL %s iwrite[%0d]: en=%0b be=%h addr=%h dat=%h, required 1 f %h %h",
                 name, k, iq[k].en, iq[k].be, iq[k].addr, iq[k].dat, 12'(k * 4), w[2 + nd + k]);
      end
      if (2 + nd + k < acc_q.size()) begin
        n_cmp++;
        if (iq[k].cyc !== acc_q[2 + nd + k]) begin
          n_fail++;
          $display("FAIL %s iwrite[%0d] cycle: %0d, required %0d", name, k, iq[k].cyc, acc_q[2 + nd + k]);
        end
      end
    end
    n_cmp++;
    if ({error, done, pc_stall, d_bram_init_done, s_ready} !== {exp_err, !exp_err, exp_err, !exp_err, 1'b0}) begin
      n_fail++;
      $display("FAIL %s status err/done/stall/init/ready: %b%b%b%b%b, required %b%b%b%b0", name,
               error, done, pc_stall, d_bram_init_done, s_ready, exp_err, !exp_err, exp_err, !exp_err);
    end
    if (!exp_err && acc_q.size() > 0) begin
      last = acc_q[acc_q.size() - 1];
      n_cmp++;
      if (done_cyc !== last + 1 || stall_cyc !== last + 1) begin
        n_fail++;
        $display("FAIL %s release edge: done at %0d stall-drop at %0d, required %0d",
                 name, done_cyc, stall_cyc, last + 1);
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    n_cmp++;
    if ({s_ready, pc_stall, done, error, d_bram_init_done} !== 5'b01000) begin
      n_fail++;
      $display("FAIL reset flags ready/stall/done/err/init: %b%b%b%b%b, required 01000",
               s_ready, pc_stall, done, error, d_bram_init_done);
    end
    n_cmp++;
    if ({i_w_addr, i_w_dat, i_w_enb, i_w_byte_enb, d_w_addr, d_w_dat, d_w_enb, d_w_byte_enb} !== '0) begin
      n_fail++;
      $display("FAIL reset write ports: i %h %h %b %h d %h %h %b %h, required all zero",
               i_w_addr, i_w_dat, i_w_enb, i_w_byte_enb, d_w_addr, d_w_dat, d_w_enb, d_w_byte_enb);
    end
    @(negedge clk); rst = 1'b1;
    dq.delete(); iq.delete();
    s_valid = 1'b1; s_data = 32'd5;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (s_ready !== 1'b0 || dq.size() != 0 || iq.size() != 0 || pc_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL idle hold: ready=%b stall=%b writes=%0d, required ready=0 stall=1 writes=0",
               s_ready, pc_stall, dq.size() + iq.size());
    end
    s_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    wq_t pay = '{32'h1, 32'h3, 32'h5};
    pay = {pay, rnd(7)};
    test_stream("b2b", mk(7, 3, pay, 16'h0), 0);
  endtask

  task automatic test_throttled();
    wq_t pay = '{32'h1, 32'h3, 32'h5};
    pay = {pay, rnd(7)};
    test_stream("toggle", mk(7, 3, pay, 16'h0), 1);
  endtask

  task automatic test_empty();
    wq_t none;
    test_stream("empty", mk(0, 0, none, 16'h0), 0);
  endtask

  task automatic test_reset_mid();
    wq_t w = '{32'd1, 32'd3, 32'hAAAA0001, 32'hBBBB0002};
    acc_q.delete();
    drive(w, 0);
    n_cmp++;
    if (d_w_enb !== 1'b1 || d_w_addr !== 12'h4) begin
      n_fail++;
      $display("FAIL midload write before reset: enb=%b addr=%h, required 1 004", d_w_enb, d_w_addr);
    end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if ({pc_stall, d_bram_init_done, s_ready, d_w_enb, d_w_byte_enb, i_w_enb} !== 9'b100000000) begin
      n_fail++;
      $display("FAIL midload async reset stall/init/ready/denb/dbe/ienb: %b %b %b %b %h %b, required 1 0 0 0 0 0",
               pc_stall, d_bram_init_done, s_ready, d_w_enb, d_w_byte_enb, i_w_enb);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_error();
    wq_t e1 = '{32'd1025, 32'd2};
    wq_t e2 = '{32'd0, 32'd1025};
    test_stream("err_ni", e1, 0);
    test_stream("recover", mk(4, 2, rnd(6), 16'h1234), 2);
    test_stream("err_nd", e2, 2);
    test_stream("limit", mk(0, 1024, rnd(1024), 16'h0), 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      int ni = $urandom_range(12, 0);
      int nd = $urandom_range(12, 0);
      test_stream("random", mk(ni, nd, rnd(ni + nd), 16'($urandom)), $urandom_range(2, 0));
    end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    wq_t pay = '{32'h1, 32'h3, 32'h5, 32'h13};
    wq_t w = mk(1, 3, pay, 16'h0);
    test_stream("chk_good", w, 0);
    w[w.size() - 1] = 32'h1D;
    test_stream("chk_bad", w, 1);
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_throttled();
    test_empty();
    test_reset_mid();
    test_error();
    test_random();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
